// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
//
// Request-side bus between the write requesters (ALU writeback, load return,
// I/O input, ...) and rf_write_arbiter. Each requester owns one bit of
// req_valid / req_ready and one slice of req_addr / req_data.
//
// Signals:
//   req_valid [NUM_REQ]             bit i: requester i has a write pending
//   req_addr  [NUM_REQ*ADDR_WIDTH]  requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data  [NUM_REQ*DATA_WIDTH]  requester i data at    [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready [NUM_REQ]             one-hot or zero; bit i: requester i transfers now
//
// Modports:
//   master  - the requester side (drives valid/addr/data, observes ready)
//   slave   - the arbiter side   (observes valid/addr/data, drives ready)
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the register file's single write port among NUM_REQ requesters.
// One write is accepted per cycle through a valid/ready handshake; the
// winner is chosen round-robin starting at an internal pointer that moves
// just past the last requester served. The accepted write is registered
// and presented to the register bank on flagRF / addressWrite / data in the
// following cycle. Writes addressed to register 0 are acknowledged but never
// raise flagRF.
//
// Parameters:
//   NUM_REQ     number of requesters (2..8)
//   DATA_WIDTH  write data width
//   ADDR_WIDTH  register address width
//   CNT_WIDTH   width of the saturating collision counter
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   hold             1 = issue no grant this cycle (control-unit freeze)
//   req              request bus, slave side (valid/addr/data in, ready out)
//   flagRF           registered register-file write enable
//   addressWrite     registered register-file write address
//   data             registered register-file write data
//   grant_id         registered index of the last accepted requester
//   collision_count  saturating count of un-held cycles with >= 2 requests
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hold,
    rf_write_arbiter_if.slave     req,
    output logic                  flagRF,
    output logic [ADDR_WIDTH-1:0] addressWrite,
    output logic [DATA_WIDTH-1:0] data,
    output logic [2:0]            grant_id,
    output logic [CNT_WIDTH-1:0]  collision_count
);

    localparam int PTR_WIDTH = $clog2(NUM_REQ);

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("rf_write_arbiter: NUM_REQ must lie in 2..8");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    ptr_t                  ptr_q,   ptr_d;
    logic                  flag_q,  flag_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [2:0]            gid_q,   gid_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

    // -----------------------------------------------------------------------
    // Grant path
    // -----------------------------------------------------------------------
    logic [2*NUM_REQ-1:0]  valid_dbl;
    logic [NUM_REQ-1:0]    valid_rot;
    ptr_t                  offset;
    logic [PTR_WIDTH:0]    grant_sum;
    ptr_t                  grant_idx;
    logic                  grant_any;
    logic [NUM_REQ-1:0]    ready;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  contended;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        offset   = '0;
        ready    = '0;
        sel_addr = '0;
        sel_data = '0;

        // Rotate the request vector so bit 0 is the requester at ptr_q; the
        // lowest set bit of the rotated vector is then the round-robin winner.
        valid_dbl = {req.req_valid, req.req_valid};
        valid_rot = valid_dbl[ptr_q +: NUM_REQ];

        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                offset = ptr_t'(k);
            end
        end

        // Undo the rotation: (ptr + offset) mod NUM_REQ.
        grant_sum = {1'b0, ptr_q} + {1'b0, offset};
        if (grant_sum >= (PTR_WIDTH+1)'(NUM_REQ)) begin
            grant_sum = grant_sum - (PTR_WIDTH+1)'(NUM_REQ);
        end
        grant_idx = grant_sum[PTR_WIDTH-1:0];

        // reset is active-low: no requester may see ready while it is held.
        grant_any = reset && !hold && (|req.req_valid);

        for (int i = 0; i < NUM_REQ; i++) begin
            ready[i] = grant_any && (grant_idx == ptr_t'(i));
        end

        // ready is one-hot or zero, so at most one slice is selected.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready[i]) begin
                sel_addr = req.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req.req_ready = ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        ptr_d  = ptr_q;
        flag_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        gid_d  = gid_q;
        cnt_d  = cnt_q;

        if (grant_any) begin
            ptr_d  = (grant_idx == ptr_t'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            // Register 0 is hard-wired: the write is acknowledged and the
            // pointer still moves, but the bank never sees an enable.
            flag_d = |sel_addr;
            addr_d = sel_addr;
            data_d = sel_data;
            gid_d  = 3'(grant_idx);
        end

        // A contended cycle is an un-held cycle with two or more requests.
        contended = !hold && ($countones(req.req_valid) > 1);
        if (contended && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            flag_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            flag_q <= flag_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gid_q  <= gid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign flagRF          = flag_q;
    assign addressWrite    = addr_q;
    assign data            = data_q;
    assign grant_id        = gid_q;
    assign collision_count = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Self-checking bench for rf_write_arbiter: a table of directed vectors,
// hand-written reset and saturation sequences, and a randomized run checked
// against a round-robin reference model kept in plain integer arithmetic.
// A second instance with CNT_WIDTH = 4 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int SW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic hold  = 1'b0;
    logic hold_s = 1'b0;

    always #5 clock = ~clock;

    rf_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus   ();
    rf_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_s ();

    logic          flag_rf,  flag_rf_s;
    logic [AW-1:0] addr_wr,  addr_wr_s;
    logic [DW-1:0] wr_data,  wr_data_s;
    logic [2:0]    gid,      gid_s;
    logic [CW-1:0] coll;
    logic [SW-1:0] coll_s;

    rf_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
        .clock           (clock),
        .reset           (reset),
        .hold            (hold),
        .req             (bus),
        .flagRF          (flag_rf),
        .addressWrite    (addr_wr),
        .data            (wr_data),
        .grant_id        (gid),
        .collision_count (coll)
    );

    rf_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(SW)) u_sat (
        .clock           (clock),
        .reset           (reset),
        .hold            (hold_s),
        .req             (bus_s),
        .flagRF          (flag_rf_s),
        .addressWrite    (addr_wr_s),
        .data            (wr_data_s),
        .grant_id        (gid_s),
        .collision_count (coll_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hold  = 1'b0;
        bus.req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic                 rst;
        logic                 hold;
        logic [N-1:0]         valid;
        logic [N-1:0][AW-1:0] addr;
        logic [N-1:0][DW-1:0] data;
        logic [N-1:0]         exp_ready;
        logic                 exp_flag;
        logic [AW-1:0]        exp_addr;
        logic [DW-1:0]        exp_data;
        logic [2:0]           exp_gid;
        logic [CW-1:0]        exp_cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic hld, input logic [N-1:0] valid,
        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
        input logic [N-1:0] e_ready, input logic e_flag, input logic [AW-1:0] e_addr,
        input logic [DW-1:0] e_data, input logic [2:0] e_gid, input logic [CW-1:0] e_cnt);
        vec_t v;
        v.rst = rst;  v.hold = hld;  v.valid = valid;
        v.addr = {a2, a1, a0};
        v.data = {d2, d1, d0};
        v.exp_ready = e_ready; v.exp_flag = e_flag; v.exp_addr = e_addr;
        v.exp_data = e_data;   v.exp_gid = e_gid;   v.exp_cnt = e_cnt;
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t          vecs[$];
        vec_t          v;
        int            ptr_m, g, nvalid, idx;
        bit            pend[N];
        logic [AW-1:0] pa[N];
        logic [DW-1:0] pd[N];
        logic [N-1:0]  e_ready;
        logic          e_flag;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        int            e_gid, e_cnt;

        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus_s.req_valid = '0;
        bus_s.req_addr  = '0;
        bus_s.req_data  = '0;

        // Reset state
        do_reset();
        #1;
        check("reset flagRF", flag_rf, 0);
        check("reset addressWrite", addr_wr, 0);
        check("reset data", wr_data, 0);
        check("reset grant_id", gid, 0);
        check("reset collision_count", coll, 0);

        // ---------------- directed vector table ----------------
        // single write
        vecs.push_back(mk(1,0,3'b010, 0,7,0, 0,32'hDEADBEEF,0, 3'b010, 1,7,32'hDEADBEEF,1,0));
        vecs.push_back(mk(0,0,3'b000, 0,7,0, 0,32'hDEADBEEF,0, 3'b000, 0,7,32'hDEADBEEF,1,0));
        // round robin, all three valid
        vecs.push_back(mk(1,0,3'b111, 1,2,3, 32'hA1,32'hA2,32'hA3, 3'b001, 1,1,32'hA1,0,1));
        vecs.push_back(mk(0,0,3'b111, 1,2,3, 32'hA1,32'hA2,32'hA3, 3'b010, 1,2,32'hA2,1,2));
        vecs.push_back(mk(0,0,3'b111, 1,2,3, 32'hA1,32'hA2,32'hA3, 3'b100, 1,3,32'hA3,2,3));
        vecs.push_back(mk(0,0,3'b111, 1,2,3, 32'hA1,32'hA2,32'hA3, 3'b001, 1,1,32'hA1,0,4));
        vecs.push_back(mk(0,0,3'b111, 1,2,3, 32'hA1,32'hA2,32'hA3, 3'b010, 1,2,32'hA2,1,5));
        vecs.push_back(mk(0,0,3'b111, 1,2,3, 32'hA1,32'hA2,32'hA3, 3'b100, 1,3,32'hA3,2,6));
        // register 0: acknowledged, no enable, pointer advances
        vecs.push_back(mk(1,0,3'b001, 0,0,0, 32'h55,0,0, 3'b001, 0,0,32'h55,0,0));
        vecs.push_back(mk(0,0,3'b011, 4,9,0, 32'h40,32'h90,0, 3'b010, 1,9,32'h90,1,1));
        vecs.push_back(mk(0,0,3'b001, 4,9,0, 32'h40,32'h90,0, 3'b001, 1,4,32'h40,0,1));
        // hold for three cycles, then release
        vecs.push_back(mk(1,1,3'b101, 10,0,12, 32'h100,0,32'h300, 3'b000, 0,0,0,0,0));
        vecs.push_back(mk(0,1,3'b101, 10,0,12, 32'h100,0,32'h300, 3'b000, 0,0,0,0,0));
        vecs.push_back(mk(0,1,3'b101, 10,0,12, 32'h100,0,32'h300, 3'b000, 0,0,0,0,0));
        vecs.push_back(mk(0,0,3'b101, 10,0,12, 32'h100,0,32'h300, 3'b001, 1,10,32'h100,0,1));
        vecs.push_back(mk(0,0,3'b100, 10,0,12, 32'h100,0,32'h300, 3'b100, 1,12,32'h300,2,1));
        vecs.push_back(mk(0,0,3'b000, 10,0,12, 32'h100,0,32'h300, 3'b000, 0,12,32'h300,2,1));
        // hold with contention, then hold right after a transfer
        vecs.push_back(mk(0,1,3'b011, 10,11,12, 32'h100,32'h110,32'h300, 3'b000, 0,12,32'h300,2,1));
        vecs.push_back(mk(0,0,3'b011, 10,11,12, 32'h100,32'h110,32'h300, 3'b001, 1,10,32'h100,0,2));
        vecs.push_back(mk(0,1,3'b010, 10,11,12, 32'h100,32'h110,32'h300, 3'b000, 0,10,32'h100,0,2));
        vecs.push_back(mk(0,0,3'b010, 10,11,12, 32'h100,32'h110,32'h300, 3'b010, 1,11,32'h110,1,2));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) do_reset();
            hold          = v.hold;
            bus.req_valid = v.valid;
            bus.req_addr  = v.addr;
            bus.req_data  = v.data;
            #1;
            check($sformatf("vec%0d req_ready", i), bus.req_ready, v.exp_ready);
            tick();
            check($sformatf("vec%0d flagRF", i), flag_rf, v.exp_flag);
            check($sformatf("vec%0d addressWrite", i), addr_wr, v.exp_addr);
            check($sformatf("vec%0d data", i), wr_data, v.exp_data);
            check($sformatf("vec%0d grant_id", i), gid, v.exp_gid);
            check($sformatf("vec%0d collision_count", i), coll, v.exp_cnt);
        end

        // ---------------- reset mid-stream ----------------
        do_reset();
        bus.req_valid = 3'b011;
        bus.req_addr  = {5'd0, 5'd6, 5'd3};
        bus.req_data  = {32'h0, 32'h66, 32'h33};
        tick();
        check("midrst staged flagRF", flag_rf, 1);
        check("midrst staged count", coll, 1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst flagRF", flag_rf, 0);
        check("midrst addressWrite", addr_wr, 0);
        check("midrst data", wr_data, 0);
        check("midrst grant_id", gid, 0);
        check("midrst collision_count", coll, 0);
        check("midrst req_ready", bus.req_ready, 3'b000);
        tick();
        reset = 1'b1;
        #1;
        // pointer was 1 before reset; a cleared pointer serves requester 0
        check("midrst ptr cleared", bus.req_ready, 3'b001);
        tick();
        check("midrst first grant flagRF", flag_rf, 1);
        check("midrst first grant addr", addr_wr, 3);
        bus.req_valid = 3'b100;
        bus.req_addr  = {5'd5, 5'd6, 5'd3};
        bus.req_data  = {32'h77, 32'h66, 32'h33};
        #2;
        reset = 1'b0;
        #1;
        check("midrst2 req_ready in reset", bus.req_ready, 3'b000);
        tick();
        reset = 1'b1;
        #1;
        check("midrst2 req_ready", bus.req_ready, 3'b100);
        tick();
        check("midrst2 flagRF", flag_rf, 1);
        check("midrst2 addressWrite", addr_wr, 5);
        check("midrst2 data", wr_data, 32'h77);
        check("midrst2 grant_id", gid, 2);
        bus.req_valid = '0;

        // ---------------- saturation (CNT_WIDTH = 4) ----------------
        do_reset();
        bus_s.req_valid = 3'b011;
        bus_s.req_addr  = {5'd0, 5'd2, 5'd1};
        bus_s.req_data  = {32'h0, 32'h2, 32'h1};
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("sat count c%0d", k), coll_s, (k < 15) ? k : 15);
        end
        bus_s.req_valid = '0;

        // ---------------- randomized vs reference model ----------------
        do_reset();
        ptr_m  = 0;
        e_flag = 1'b0;
        e_addr = '0;
        e_data = '0;
        e_gid  = 0;
        e_cnt  = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pa[i]   = '0;
            pd[i]   = '0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
                    pend[i] = 1'b1;
                    pa[i]   = ($urandom_range(3, 0) == 0) ? '0 : AW'($urandom);
                    pd[i]   = $urandom;
                end
                bus.req_valid[i]          = pend[i];
                bus.req_addr[i*AW +: AW]  = pa[i];
                bus.req_data[i*DW +: DW]  = pd[i];
            end
            hold = ($urandom_range(4, 0) == 0);

            nvalid = 0;
            for (int i = 0; i < N; i++) nvalid += int'(pend[i]);
            g = -1;
            if (!hold) begin
                for (int k = 0; k < N; k++) begin
                    idx = (ptr_m + k) % N;
                    if (g < 0 && pend[idx]) g = idx;
                end
            end
            e_ready = (g >= 0) ? N'(1 << g) : '0;

            #1;
            check($sformatf("rnd%0d req_ready", cyc), bus.req_ready, e_ready);

            if (g >= 0) begin
                e_flag  = (pa[g] != 0);
                e_addr  = pa[g];
                e_data  = pd[g];
                e_gid   = g;
                ptr_m   = (g + 1) % N;
                pend[g] = 1'b0;
            end else begin
                e_flag = 1'b0;
            end
            if (!hold && nvalid >= 2 && e_cnt < (1 << CW) - 1) e_cnt++;

            tick();
            check($sformatf("rnd%0d flagRF", cyc), flag_rf, e_flag);
            check($sformatf("rnd%0d addressWrite", cyc), addr_wr, e_addr);
            check($sformatf("rnd%0d data", cyc), wr_data, e_data);
            check($sformatf("rnd%0d grant_id", cyc), gid, e_gid);
            check($sformatf("rnd%0d collision_count", cyc), coll, e_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
